ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter WIDTH, default 16, data word width.
REQ-002 Parameter DEPTH, default 8, number of memory words.
REQ-003 Parameter ADDR_W, default 3, address width, equal to log2(DEPTH).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  2  per-client access request; bit i belongs to client i.
REQ-007 we  input  2  per-client operation; 1 = write, 0 = read; qualified by req.
REQ-008 addr0 / addr1  input  ADDR_W each  client 0 and client 1 word address.
REQ-009 wdata0 / wdata1  input  WIDTH each  client 0 and client 1 write data.
REQ-010 gnt  output  2  combinational grant; at most one bit high.
REQ-011 rvalid  output  2  registered read-data-valid, one per client.
REQ-012 rdata  output  WIDTH  registered read data, shared by both clients.
REQ-013 init_done  output  1  high once the post-reset memory clear has completed.

Function
REQ-014 The block SHALL own one DEPTH x WIDTH memory and perform at most one access (read or write) per cycle.
REQ-015 States SHALL be INIT and RUN; reset enters INIT; INIT goes to RUN after the clear completes; RUN has no exit except reset.
REQ-016 In INIT, a 3-bit counter SHALL write 0 to address cnt on each edge: first edge with reset low clears address 0, eighth clears address 7 and sets init_done=1.
REQ-017 While init_done=0, gnt SHALL be 2'b00 regardless of req.
REQ-018 In RUN, a single requester SHALL be granted in the same cycle: gnt[i] = req[i] when req[~i]=0.
REQ-019 When both clients request, gnt SHALL go to the client not granted most recently (round-robin); after reset, client 0 wins the first tie.
REQ-020 The last-grant pointer SHALL update only on a cycle with a grant.
REQ-021 A granted write SHALL store the winner's wdata at the winner's addr on that edge.
REQ-022 A granted read SHALL set rdata = mem[addr] and rvalid[winner]=1 on that edge, giving one-cycle latency; rvalid SHALL drop after one cycle unless another read is granted.
REQ-023 rdata SHALL hold its last value when no read is granted.
REQ-024 A client SHALL hold req, we, addr and wdata stable until it sees gnt high; the block does not queue requests.
REQ-025 A read granted on the cycle after a write to the same address SHALL return the new data.
REQ-026 Address wrap is not applicable: all ADDR_W codes are valid when DEPTH = 2^ADDR_W.

Reset
REQ-027 reset=1 on any edge SHALL clear rvalid, rdata and init_done to 0, reset the counter to 0 and the last-grant pointer to 1, and enter INIT.
REQ-028 Reset in the middle of INIT or RUN SHALL discard any in-flight read (rvalid=0 on the next cycle) and restart the full 8-cycle clear.
REQ-029 gnt SHALL be 0 during every cycle in which reset=1.

Structure
REQ-030 A shared package SHALL hold WIDTH/DEPTH/ADDR_W defaults and the INIT/RUN state encoding.
REQ-031 The two-client round-robin arbiter SHALL be a sub-module, rr_arb2 (inputs req, last, enable; output gnt).
REQ-032 The memory array SHALL be inferred inside ram_port_arbiter; it SHALL have no reset of its own beyond the INIT clear.

Verification
REQ-033 Release reset, then hold req=2'b11 -> gnt=0 for 8 cycles, init_done=1 after the 8th edge, and a read of every address returns 16'h0000.
REQ-034 Client 0 writes 16'h0014 to address 3; client 1 reads address 3 on the next cycle -> rdata=16'h0014 with rvalid=2'b10 one cycle later.
REQ-035 Both clients hold req high with reads for 4 cycles -> gnt sequence 01, 10, 01, 10.
REQ-036 Client 0 only, writing addresses 0..7 with data 20..27, then reading them back -> gnt[0] high every cycle and rdata=20..27 in order.
REQ-037 Assert reset on the cycle after a granted read -> rvalid=0, init_done=0, the 8-cycle clear repeats, and address 3 reads 0 afterwards.

Source files
------------

// File: rtl/ram_port_arbiter_pkg.sv
// Shared defaults and controller state encoding for the two-client RAM port arbiter.
package ram_port_arbiter_pkg;

   localparam int WIDTH_DEF  = 16;
   localparam int DEPTH_DEF  = 8;
   localparam int ADDR_W_DEF = 3;

   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-client round-robin arbiter; a tie goes to the client that was not granted last.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   input  logic       enable,
   output logic [1:0] gnt
);

   // Grant decode: single requester wins outright, tie resolved against the last winner
   always_comb begin
      gnt = 2'b00;
      if (enable) begin
         case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
         endcase
      end else begin
         gnt = 2'b00;
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Single-port RAM shared by two clients; clears itself after reset, then arbitrates round-robin.
module ram_port_arbiter
   import ram_port_arbiter_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        req,
   input  logic [1:0]        we,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [WIDTH-1:0]  wdata0,
   input  logic [WIDTH-1:0]  wdata1,
   output logic [1:0]        gnt,
   output logic [1:0]        rvalid,
   output logic [WIDTH-1:0]  rdata,
   output logic              init_done
);

   localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

   logic [WIDTH-1:0]  mem [DEPTH];
   logic [0:0]        state;
   logic [ADDR_W-1:0] cnt;
   logic              last;
   logic              enable;
   logic [ADDR_W-1:0] acc_addr;
   logic [WIDTH-1:0]  acc_wdata;
   logic              acc_we;
   logic              wr_en;

   // Reset gates the grant combinationally so no access can slip through on a reset edge
   assign enable = init_done & ~reset;
   assign wr_en  = (|gnt) & acc_we;

   rr_arb2 u_arb (
      .req    (req),
      .last   (last),
      .enable (enable),
      .gnt    (gnt)
   );

   // Route the winning client's operation onto the single memory port
   always_comb begin
      acc_addr  = addr0;
      acc_wdata = wdata0;
      acc_we    = we[0];
      if (gnt[1]) begin
         acc_addr  = addr1;
         acc_wdata = wdata1;
         acc_we    = we[1];
      end else begin
         acc_addr  = addr0;
         acc_wdata = wdata0;
         acc_we    = we[0];
      end
   end

   // Memory array: cleared word by word during INIT, otherwise written by granted writes
   always_ff @(posedge clk) begin
      if (!reset && state == ST_INIT) begin
         mem[cnt] <= {WIDTH{1'b0}};
      end else if (wr_en) begin
         mem[acc_addr] <= acc_wdata;
      end
   end

   // Controller: clear sequencing, round-robin history and registered read return
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_INIT;
         cnt       <= {ADDR_W{1'b0}};
         init_done <= 1'b0;
         last      <= 1'b1;
         rvalid    <= 2'b00;
         rdata     <= {WIDTH{1'b0}};
      end else begin
         case (state)
            ST_INIT: begin
               rvalid <= 2'b00;
               cnt    <= cnt + ADDR_W'(1);
               if (cnt == CNT_LAST) begin
                  state     <= ST_RUN;
                  init_done <= 1'b1;
               end
            end
            ST_RUN: begin
               rvalid <= 2'b00;
               if (|gnt) begin
                  last <= gnt[1];
                  if (!acc_we) begin
                     rdata  <= mem[acc_addr];
                     rvalid <= gnt;
                  end
               end
            end
            default: begin
               state     <= ST_INIT;
               cnt       <= {ADDR_W{1'b0}};
               init_done <= 1'b0;
               rvalid    <= 2'b00;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed self-checking bench for ram_port_arbiter; inputs change and outputs are sampled on the falling edge.
module tb_ram_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req;
   logic [1:0]  we;
   logic [2:0]  addr0;
   logic [2:0]  addr1;
   logic [15:0] wdata0;
   logic [15:0] wdata1;
   logic [1:0]  gnt;
   logic [1:0]  rvalid;
   logic [15:0] rdata;
   logic        init_done;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   ram_port_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .we        (we),
      .addr0     (addr0),
      .addr1     (addr1),
      .wdata0    (wdata0),
      .wdata1    (wdata1),
      .gnt       (gnt),
      .rvalid    (rvalid),
      .rdata     (rdata),
      .init_done (init_done)
   );

   task automatic drive(input logic [1:0] r, input logic [1:0] w,
                        input logic [2:0] a0, input logic [2:0] a1,
                        input logic [15:0] d0, input logic [15:0] d1);
      req = r; we = w; addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(2'b11, 2'b00, 3'd0, 3'd0, 16'h0000, 16'h0000);
      repeat (3) @(negedge clk);
      tests_run++;
      if (gnt !== 2'b00) begin
         tests_failed++; $display("FAIL reset_gnt: got %b want 00", gnt);
      end
      tests_run++;
      if (rvalid !== 2'b00 || rdata !== 16'h0000 || init_done !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_regs: rvalid=%b rdata=%h init_done=%b want 00/0000/0", rvalid, rdata, init_done);
      end
   endtask

   task automatic test_init_clear();
      reset = 1'b0;
      drive(2'b11, 2'b00, 3'd0, 3'd0, 16'h0000, 16'h0000);
      for (int i = 0; i < 8; i++) begin
         tests_run++;
         if (gnt !== 2'b00 || init_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL init_cycle%0d: gnt=%b init_done=%b want 00/0", i, gnt, init_done);
         end
         @(negedge clk);
      end
      tests_run++;
      if (init_done !== 1'b1) begin
         tests_failed++; $display("FAIL init_done: got %b want 1", init_done);
      end
      for (int i = 0; i < 8; i++) begin
         drive(2'b01, 2'b00, 3'(i), 3'd0, 16'h0000, 16'h0000);
         tests_run++;
         if (gnt !== 2'b01) begin
            tests_failed++; $display("FAIL init_read_gnt%0d: got %b want 01", i, gnt);
         end
         @(negedge clk);
         tests_run++;
         if (rvalid !== 2'b01 || rdata !== 16'h0000) begin
            tests_failed++;
            $display("FAIL init_read%0d: rvalid=%b rdata=%h want 01/0000", i, rvalid, rdata);
         end
      end
   endtask

   task automatic test_write_then_read();
      drive(2'b01, 2'b01, 3'd3, 3'd0, 16'h0014, 16'h0000);
      tests_run++;
      if (gnt !== 2'b01) begin
         tests_failed++; $display("FAIL wr_gnt: got %b want 01", gnt);
      end
      @(negedge clk);
      tests_run++;
      if (rvalid !== 2'b00) begin
         tests_failed++; $display("FAIL wr_rvalid: got %b want 00", rvalid);
      end
      drive(2'b10, 2'b00, 3'd0, 3'd3, 16'h0000, 16'h0000);
      tests_run++;
      if (gnt !== 2'b10) begin
         tests_failed++; $display("FAIL rd1_gnt: got %b want 10", gnt);
      end
      @(negedge clk);
      tests_run++;
      if (rvalid !== 2'b10 || rdata !== 16'h0014) begin
         tests_failed++; $display("FAIL rd1_data: rvalid=%b rdata=%h want 10/0014", rvalid, rdata);
      end
      drive(2'b00, 2'b00, 3'd0, 3'd0, 16'h0000, 16'h0000);
      @(negedge clk);
      tests_run++;
      if (rvalid !== 2'b00 || rdata !== 16'h0014) begin
         tests_failed++; $display("FAIL idle_hold: rvalid=%b rdata=%h want 00/0014", rvalid, rdata);
      end
   endtask

   task automatic test_round_robin();
      logic [1:0]  exp_gnt [4];
      logic [15:0] exp_dat [4];
      exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
      exp_dat = '{16'h0014, 16'h0000, 16'h0014, 16'h0000};
      drive(2'b11, 2'b00, 3'd3, 3'd0, 16'h0000, 16'h0000);
      for (int k = 0; k < 4; k++) begin
         tests_run++;
         if (gnt !== exp_gnt[k]) begin
            tests_failed++; $display("FAIL rr_gnt%0d: got %b want %b", k, gnt, exp_gnt[k]);
         end
         @(negedge clk);
         tests_run++;
         if (rvalid !== exp_gnt[k] || rdata !== exp_dat[k]) begin
            tests_failed++;
            $display("FAIL rr_data%0d: rvalid=%b rdata=%h want %b/%h", k, rvalid, rdata, exp_gnt[k], exp_dat[k]);
         end
      end
   endtask

   task automatic test_client0_sweep();
      for (int i = 0; i < 8; i++) begin
         drive(2'b01, 2'b01, 3'(i), 3'd0, 16'(20 + i), 16'h0000);
         tests_run++;
         if (gnt !== 2'b01) begin
            tests_failed++; $display("FAIL sweep_wr_gnt%0d: got %b want 01", i, gnt);
         end
         @(negedge clk);
      end
      for (int i = 0; i < 8; i++) begin
         drive(2'b01, 2'b00, 3'(i), 3'd0, 16'h0000, 16'h0000);
         tests_run++;
         if (gnt !== 2'b01) begin
            tests_failed++; $display("FAIL sweep_rd_gnt%0d: got %b want 01", i, gnt);
         end
         @(negedge clk);
         tests_run++;
         if (rvalid !== 2'b01 || rdata !== 16'(20 + i)) begin
            tests_failed++;
            $display("FAIL sweep_rd%0d: rvalid=%b rdata=%h want 01/%h", i, rvalid, rdata, 16'(20 + i));
         end
      end
   endtask

   task automatic test_reset_midway();
      drive(2'b01, 2'b00, 3'd3, 3'd0, 16'h0000, 16'h0000);
      @(negedge clk);
      tests_run++;
      if (rvalid !== 2'b01 || rdata !== 16'd23) begin
         tests_failed++; $display("FAIL pre_reset_read: rvalid=%b rdata=%h want 01/0017", rvalid, rdata);
      end
      reset = 1'b1;
      drive(2'b11, 2'b00, 3'd3, 3'd3, 16'h0000, 16'h0000);
      tests_run++;
      if (gnt !== 2'b00) begin
         tests_failed++; $display("FAIL reset_gnt_mid: got %b want 00", gnt);
      end
      @(negedge clk);
      tests_run++;
      if (rvalid !== 2'b00 || init_done !== 1'b0 || rdata !== 16'h0000) begin
         tests_failed++;
         $display("FAIL mid_reset: rvalid=%b init_done=%b rdata=%h want 00/0/0000", rvalid, init_done, rdata);
      end
      // Interrupt the clear partway, then make sure the full clear restarts
      reset = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      repeat (7) @(negedge clk);
      tests_run++;
      if (init_done !== 1'b0 || gnt !== 2'b00) begin
         tests_failed++; $display("FAIL restart_7: init_done=%b gnt=%b want 0/00", init_done, gnt);
      end
      @(negedge clk);
      tests_run++;
      if (init_done !== 1'b1) begin
         tests_failed++; $display("FAIL restart_8: init_done=%b want 1", init_done);
      end
      drive(2'b01, 2'b00, 3'd3, 3'd0, 16'h0000, 16'h0000);
      @(negedge clk);
      tests_run++;
      if (rvalid !== 2'b01 || rdata !== 16'h0000) begin
         tests_failed++; $display("FAIL post_reset_read: rvalid=%b rdata=%h want 01/0000", rvalid, rdata);
      end
      drive(2'b11, 2'b00, 3'd5, 3'd7, 16'h0000, 16'h0000);
      tests_run++;
      if (gnt !== 2'b10) begin
         tests_failed++; $display("FAIL post_reset_tie: got %b want 10", gnt);
      end
   endtask

   initial begin
      reset = 1'b1;
      req = 2'b00; we = 2'b00; addr0 = 3'd0; addr1 = 3'd0; wdata0 = 16'h0000; wdata1 = 16'h0000;
      @(negedge clk);
      test_reset();
      test_init_clear();
      test_write_then_read();
      test_round_robin();
      test_client0_sweep();
      test_reset_midway();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
